// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, issue, writeback and control signals of decode_stage
// slave is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
);
   logic                     instr_valid;
   logic [DATA_WIDTH-1:0]    instr;
   logic [DATA_WIDTH-1:0]    pc;
   logic                     instr_ready;
   logic                     dec_valid;
   logic                     dec_ready;
   logic [ADDRESS_WIDTH-1:0] ad1;
   logic [ADDRESS_WIDTH-1:0] ad2;
   logic [ADDRESS_WIDTH-1:0] rd;
   logic [DATA_WIDTH-1:0]    imm;
   logic [DATA_WIDTH-1:0]    pc_out;
   logic [DATA_WIDTH-1:0]    instr_out;
   logic                     writes_rd;
   logic                     uses_rs1;
   logic                     uses_rs2;
   logic                     illegal;
   logic                     wb_we;
   logic [ADDRESS_WIDTH-1:0] wb_ad;
   logic                     flush;
   logic                     sb_clr;

   modport slave (
      input  instr_valid, instr, pc, dec_ready, wb_we, wb_ad, flush, sb_clr,
      output instr_ready, dec_valid, ad1, ad2, rd, imm, pc_out, instr_out,
             writes_rd, uses_rs1, uses_rs2, illegal
   );

   modport master (
      output instr_valid, instr, pc, dec_ready, wb_we, wb_ad, flush, sb_clr,
      input  instr_ready, dec_valid, ad1, ad2, rd, imm, pc_out, instr_out,
             writes_rd, uses_rs1, uses_rs2, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I registered decode stage with pending-write scoreboard
// DECODE_SCOREBOARD_EN enables the scoreboard and RAW hazard stall.
module decode_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   logic                     r_held_valid;
   logic [DATA_WIDTH-1:0]    r_instr;
   logic [DATA_WIDTH-1:0]    r_pc;

   logic                     w_accept;
   logic                     w_fire;
   logic                     w_hazard;
   logic                     w_dec_valid;
   logic                     w_instr_ready;
   logic [6:0]               w_opcode;
   logic [ADDRESS_WIDTH-1:0] w_rs1_field;
   logic [ADDRESS_WIDTH-1:0] w_rs2_field;
   logic [ADDRESS_WIDTH-1:0] w_rd_field;
   logic                     w_has_rd;
   logic                     w_use1;
   logic                     w_use2;
   logic                     w_ill;
   logic [DATA_WIDTH-1:0]    w_imm;
   logic [ADDRESS_WIDTH-1:0] w_ad1;
   logic [ADDRESS_WIDTH-1:0] w_ad2;
   logic [ADDRESS_WIDTH-1:0] w_rd;
   logic                     w_uses_rs1;
   logic                     w_uses_rs2;
   logic                     w_writes_rd;

   assign w_accept      = bus.instr_valid && w_instr_ready;
   assign w_fire        = w_dec_valid && bus.dec_ready;
   assign w_instr_ready = i_rst_n && (!r_held_valid || w_fire);
   assign w_dec_valid   = r_held_valid && !w_hazard;

   // Flush wins over both a same-cycle accept and a same-cycle fire.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_held_valid <= 1'b0;
         r_instr      <= '0;
         r_pc         <= '0;
      end else if (bus.flush) begin
         r_held_valid <= 1'b0;
      end else if (w_accept) begin
         r_held_valid <= 1'b1;
         r_instr      <= bus.instr;
         r_pc         <= bus.pc;
      end else if (w_fire) begin
         r_held_valid <= 1'b0;
      end
   end

   assign w_opcode    = r_instr[6:0];
   assign w_rs1_field = ADDRESS_WIDTH'(r_instr[19:15]);
   assign w_rs2_field = ADDRESS_WIDTH'(r_instr[24:20]);
   assign w_rd_field  = ADDRESS_WIDTH'(r_instr[11:7]);

   always_comb begin
      w_has_rd = 1'b0;
      w_use1   = 1'b0;
      w_use2   = 1'b0;
      w_ill    = 1'b0;
      w_imm    = '0;
      case (w_opcode)
         OP_LUI, OP_AUIPC: begin
            w_has_rd = 1'b1;
            w_imm    = DATA_WIDTH'($signed({r_instr[31:12], 12'b0}));
         end
         OP_JAL: begin
            w_has_rd = 1'b1;
            w_imm    = DATA_WIDTH'($signed({r_instr[31], r_instr[19:12], r_instr[20],
                                            r_instr[30:21], 1'b0}));
         end
         OP_JALR, OP_LOAD, OP_IMM: begin
            w_has_rd = 1'b1;
            w_use1   = 1'b1;
            w_imm    = DATA_WIDTH'($signed(r_instr[31:20]));
         end
         OP_BRANCH: begin
            w_use1 = 1'b1;
            w_use2 = 1'b1;
            w_imm  = DATA_WIDTH'($signed({r_instr[31], r_instr[7], r_instr[30:25],
                                          r_instr[11:8], 1'b0}));
         end
         OP_STORE: begin
            w_use1 = 1'b1;
            w_use2 = 1'b1;
            w_imm  = DATA_WIDTH'($signed({r_instr[31:25], r_instr[11:7]}));
         end
         OP_OP: begin
            w_has_rd = 1'b1;
            w_use1   = 1'b1;
            w_use2   = 1'b1;
         end
         default: w_ill = 1'b1;
      endcase
   end

   // Everything is gated by held_valid so an empty slot presents all-zero decode.
   assign w_uses_rs1  = r_held_valid && w_use1;
   assign w_uses_rs2  = r_held_valid && w_use2;
   assign w_ad1       = w_uses_rs1 ? w_rs1_field : '0;
   assign w_ad2       = w_uses_rs2 ? w_rs2_field : '0;
   assign w_rd        = (r_held_valid && w_has_rd) ? w_rd_field : '0;
   assign w_writes_rd = r_held_valid && w_has_rd && (w_rd_field != '0);

`ifdef DECODE_SCOREBOARD_EN
   localparam int NREG = 2 ** ADDRESS_WIDTH;

   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_set_mask;
   logic [NREG-1:0] w_clr_mask;

   assign w_set_mask = (w_fire && w_writes_rd && !bus.flush) ? (NREG'(1) << w_rd) : '0;
   assign w_clr_mask = bus.wb_we ? (NREG'(1) << bus.wb_ad) : '0;

   // Set after clear so an issuing producer wins over a same-index retire.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || bus.sb_clr) begin
         r_pending <= '0;
      end else begin
         r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
      end
   end

   assign w_hazard = r_held_valid && ((w_uses_rs1 && r_pending[w_ad1]) ||
                                      (w_uses_rs2 && r_pending[w_ad2]));
`else
   logic w_unused;
   assign w_unused = &{1'b0, bus.wb_we, bus.wb_ad, bus.sb_clr};
   assign w_hazard = 1'b0;
`endif

   assign bus.instr_ready = w_instr_ready;
   assign bus.dec_valid   = w_dec_valid;
   assign bus.ad1         = w_ad1;
   assign bus.ad2         = w_ad2;
   assign bus.rd          = w_rd;
   assign bus.imm         = r_held_valid ? w_imm : '0;
   assign bus.pc_out      = r_pc;
   assign bus.instr_out   = r_instr;
   assign bus.writes_rd   = w_writes_rd;
   assign bus.uses_rs1    = w_uses_rs1;
   assign bus.uses_rs2    = w_uses_rs2;
   assign bus.illegal     = r_held_valid && w_ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven and sequence checks for decode_stage
module tb_decode_stage;
`ifdef DECODE_SCOREBOARD_EN
   localparam bit SB = 1'b1;
`else
   localparam bit SB = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  ad1;
      logic [4:0]  ad2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  flags;   // {writes_rd, uses_rs1, uses_rs2, illegal}
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   vec_t vecs[15];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   decode_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dif ();

   decode_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (dif)
   );

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] ins, input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] r, input logic [31:0] im, input logic [3:0] fl);
      vec_t v;
      v.instr = ins;
      v.pc    = 32'h0;
      v.ad1   = a1;
      v.ad2   = a2;
      v.rd    = r;
      v.imm   = im;
      v.flags = fl;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents v until accepted; leaves instr_valid high so back-to-back sends stream.
   task automatic send(input vec_t v);
      bit done = 1'b0;
      dif.instr_valid = 1'b1;
      dif.instr       = v.instr;
      dif.pc          = v.pc;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (dif.instr_ready) begin
            exp_q.push_back(v);
            done = 1'b1;
         end
         tick();
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: instr %h not accepted within 50 cycles", v.instr);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && dif.dec_valid && dif.dec_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: instr_out %h issued with nothing expected", dif.instr_out);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            check($sformatf("decode_%h", e.instr),
                  {dif.ad1, dif.ad2, dif.rd, dif.imm,
                   dif.writes_rd, dif.uses_rs1, dif.uses_rs2, dif.illegal},
                  {e.ad1, e.ad2, e.rd, e.imm, e.flags});
            check($sformatf("pc_word_%h", e.instr), {dif.pc_out, dif.instr_out}, {e.pc, e.instr});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(32'h00500093, 5'd0, 5'd0, 5'd1, 32'h00000005, 4'b1100);
      vecs[1]  = mk(32'h00108133, 5'd1, 5'd1, 5'd2, 32'h00000000, 4'b1110);
      vecs[2]  = mk(32'h00202423, 5'd0, 5'd2, 5'd0, 32'h00000008, 4'b0110);
      vecs[3]  = mk(32'h123452B7, 5'd0, 5'd0, 5'd5, 32'h12345000, 4'b1000);
      vecs[4]  = mk(32'hFE000EE3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 4'b0110);
      vecs[5]  = mk(32'h0000007F, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'b0001);
      vecs[6]  = mk(32'hFFFFF097, 5'd0, 5'd0, 5'd1, 32'hFFFFF000, 4'b1000);
      vecs[7]  = mk(32'h008000EF, 5'd0, 5'd0, 5'd1, 32'h00000008, 4'b1000);
      vecs[8]  = mk(32'h00008067, 5'd1, 5'd0, 5'd0, 32'h00000000, 4'b0100);
      vecs[9]  = mk(32'hFFC12283, 5'd2, 5'd0, 5'd5, 32'hFFFFFFFC, 4'b1100);
      vecs[10] = mk(32'hFFF20193, 5'd4, 5'd0, 5'd3, 32'hFFFFFFFF, 4'b1100);
      vecs[11] = mk(32'h00628033, 5'd5, 5'd6, 5'd0, 32'h00000000, 4'b0110);
      vecs[12] = mk(32'hFE74AC23, 5'd9, 5'd7, 5'd0, 32'hFFFFFFF8, 4'b0110);
      vecs[13] = mk(32'h000101B3, 5'd2, 5'd0, 5'd3, 32'h00000000, 4'b1110);
      vecs[14] = mk(32'h00018233, 5'd3, 5'd0, 5'd4, 32'h00000000, 4'b1110);
      for (int i = 0; i < 15; i++) vecs[i].pc = 32'h1000 + 32'(i * 4);

      dif.instr_valid = 1'b0;
      dif.instr       = '0;
      dif.pc          = '0;
      dif.dec_ready   = 1'b0;
      dif.wb_we       = 1'b0;
      dif.wb_ad       = '0;
      dif.flush       = 1'b0;
      dif.sb_clr      = 1'b0;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("reset_instr_ready", dif.instr_ready, 1'b0);
      check("reset_dec_valid", dif.dec_valid, 1'b0);
      check("reset_outputs", {dif.ad1, dif.ad2, dif.rd, dif.imm, dif.pc_out, dif.instr_out,
                              dif.writes_rd, dif.uses_rs1, dif.uses_rs2, dif.illegal}, '0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_instr_ready", dif.instr_ready, 1'b1);
      check("post_reset_dec_valid", dif.dec_valid, 1'b0);

      // Latency: valid the cycle after acceptance
      tick();
      send(vecs[0]);
      dif.instr_valid = 1'b0;
      @(negedge clk);
      check("latency_dec_valid", dif.dec_valid, 1'b1);
      tick();
      dif.dec_ready = 1'b1;
      tick();
      dif.dec_ready = 1'b0;
      dif.sb_clr    = 1'b1;
      tick();

      // Decode table, streamed at full rate with the scoreboard held clear
      dif.dec_ready = 1'b1;
      for (int i = 0; i < 15; i++) send(vecs[i]);
      dif.instr_valid = 1'b0;
      repeat (3) tick();
      dif.dec_ready = 1'b0;
      dif.sb_clr    = 1'b0;
      tick();

      // Backpressure: outputs held for 3 cycles, issue on the 4th
      send(vecs[2]);
      dif.instr_valid = 1'b1;
      dif.instr       = 32'hDEADBEEF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("hold_%0d", k),
               {dif.dec_valid, dif.instr_ready, dif.imm, dif.ad2, dif.writes_rd, dif.instr_out},
               {1'b1, 1'b0, 32'h8, 5'd2, 1'b0, 32'h00202423});
         tick();
      end
      dif.instr_valid = 1'b0;
      dif.dec_ready   = 1'b1;
      tick();
      dif.dec_ready = 1'b0;

      // RAW hazard on x1, released the cycle after writeback
      dif.dec_ready = 1'b1;
      send(vecs[0]);
      send(vecs[1]);
      dif.instr_valid = 1'b0;
      dif.dec_ready   = 1'b0;
      @(negedge clk);
      check("raw_stall_0", dif.dec_valid, !SB);
      tick();
      @(negedge clk);
      check("raw_stall_1", dif.dec_valid, !SB);
      tick();
      dif.wb_we = 1'b1;
      dif.wb_ad = 5'd1;
      @(negedge clk);
      check("raw_no_bypass", dif.dec_valid, !SB);
      tick();
      dif.wb_we = 1'b0;
      @(negedge clk);
      check("raw_release", {dif.dec_valid, dif.ad1, dif.ad2}, {1'b1, 5'd1, 5'd1});
      tick();
      dif.dec_ready = 1'b1;
      tick();
      dif.dec_ready = 1'b0;

      // Flush of a held illegal instruction; x2 stays pending
      send(vecs[5]);
      dif.instr_valid = 1'b0;
      @(negedge clk);
      check("illegal_held", {dif.dec_valid, dif.illegal, dif.writes_rd, dif.uses_rs1, dif.uses_rs2, dif.imm},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      tick();
      dif.flush = 1'b1;
      @(negedge clk);
      check("flush_same_cycle", dif.dec_valid, 1'b1);
      tick();
      dif.flush = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("flush_cleared", {dif.dec_valid, dif.instr_ready, dif.illegal}, {1'b0, 1'b1, 1'b0});
      tick();
      send(vecs[13]);
      dif.instr_valid = 1'b0;
      @(negedge clk);
      check("flush_keeps_pending", dif.dec_valid, !SB);
      tick();
      dif.wb_we = 1'b1;
      dif.wb_ad = 5'd2;
      tick();
      dif.wb_we = 1'b0;
      @(negedge clk);
      check("x2_release", dif.dec_valid, 1'b1);

      // Issue writing x3 in the same cycle x3 retires: set wins
      tick();
      dif.dec_ready = 1'b1;
      dif.wb_we     = 1'b1;
      dif.wb_ad     = 5'd3;
      tick();
      dif.dec_ready = 1'b0;
      dif.wb_we     = 1'b0;
      send(vecs[14]);
      dif.instr_valid = 1'b0;
      @(negedge clk);
      check("set_wins", dif.dec_valid, !SB);
      tick();
      dif.sb_clr = 1'b1;
      @(negedge clk);
      check("sb_clr_next_edge", dif.dec_valid, !SB);
      tick();
      dif.sb_clr = 1'b0;
      @(negedge clk);
      check("sb_clr_released", dif.dec_valid, 1'b1);
      tick();
      dif.dec_ready = 1'b1;
      tick();
      dif.dec_ready = 1'b0;

      // Reset in the middle of holding an instruction
      send(vecs[3]);
      dif.instr_valid = 1'b0;
      @(negedge clk);
      check("pre_reset_held", {dif.dec_valid, dif.rd, dif.imm}, {1'b1, 5'd5, 32'h12345000});
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_ready_low", dif.instr_ready, 1'b0);
      tick();
      @(negedge clk);
      check("midop_reset", {dif.dec_valid, dif.pc_out, dif.rd, dif.imm}, '0);
      tick();
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("midop_reset_release", {dif.instr_ready, dif.dec_valid}, {1'b1, 1'b0});

      tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage between instruction fetch and the register file / execute path of the RV32I core. Holds one fetched instruction, decodes register addresses, immediate and write intent, and drives the register-file read addresses from registered state. A 32-entry scoreboard of pending destination writes stalls issue on read-after-write hazards until writeback retires the producer. Valid/ready handshakes on both sides.

## Interface
- `DATA_WIDTH`, 32: instruction, PC and immediate width.
- `ADDRESS_WIDTH`, 5: register address width; scoreboard has 2**ADDRESS_WIDTH entries.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_valid` in 1: fetch presents `instr`/`pc`.
- `instr` in DATA_WIDTH: instruction word.
- `pc` in DATA_WIDTH: instruction address.
- `instr_ready` out 1: stage accepts this cycle.
- `dec_valid` out 1: decoded instruction issuable.
- `dec_ready` in 1: downstream accepts.
- `ad1`, `ad2` out ADDRESS_WIDTH: rs1/rs2 to register file (0 when unused).
- `rd` out ADDRESS_WIDTH: destination register.
- `imm` out DATA_WIDTH: sign-extended immediate.
- `pc_out`, `instr_out` out DATA_WIDTH: held PC and word.
- `writes_rd`, `uses_rs1`, `uses_rs2`, `illegal` out 1: decode flags.
- `wb_we` in 1, `wb_ad` in ADDRESS_WIDTH: writeback retire; clears pending bit.
- `flush` in 1: discard held instruction.
- `sb_clr` in 1: clear whole scoreboard.

## Operation
- Holding slot: `held_valid` plus registered instr, pc. Accept = `instr_valid && instr_ready`; fire = `dec_valid && dec_ready`.
- `instr_ready = !held_valid || fire`; 0 while `rst_n`=0.
- Decode from held word only; every decoded output is a pure function of held registers (no path from `instr` input).
- Opcodes: LUI/AUIPC (U: writes_rd), JAL (J: writes_rd), JALR/LOAD/OP-IMM (I: rs1, writes_rd), BRANCH (B: rs1, rs2), STORE (S: rs1, rs2), OP (R: rs1, rs2, writes_rd). Any other opcode: `illegal`=1, all use/write flags 0, imm 0.
- `writes_rd` forced 0 when rd=0. `ad1`/`ad2` forced 0 when not used.
- Hazard = held_valid && ((uses_rs1 && pending[ad1]) || (uses_rs2 && pending[ad2])). `dec_valid = held_valid && !hazard`.
- On fire with writes_rd: pending[rd] set. On `wb_we`: pending[wb_ad] cleared. Same index both: set wins. pending[0] always 0.
- No bypass: hazard reads registered pending; producer releases consumer the cycle after wb.
- `flush`: held_valid cleared next edge, overrides accept and fire (no scoreboard set); scoreboard untouched.
- `sb_clr`: pending all 0 next edge; overrides same-cycle set.
- `illegal` instructions issue normally; trap handling is downstream.

## Timing
- Reset (rst_n=0 at edge): held_valid=0, pending=0, all data outputs 0, `dec_valid`=0, `instr_ready`=0 during reset, 1 first cycle after.
- Latency: accepted at edge N → `dec_valid` in cycle after N if no hazard.
- Throughput: 1/cycle with `dec_ready`=1 and no hazards (accept and fire same cycle).
- Outputs stable while `dec_valid && !dec_ready`; `dec_valid` never drops without fire, flush or reset.
- Reset mid-operation discards held instruction and pending bits.

## Configuration
- `DECODE_SCOREBOARD_EN` defined: scoreboard and hazard stall as above.
- Undefined: no scoreboard storage, hazard=0, `dec_valid = held_valid`; `wb_*`, `sb_clr` ignored.

## Test plan
- Reset then `0x00500093` (addi x1,x0,5) → next cycle dec_valid=1, ad1=0, rd=1, imm=5, writes_rd=1; pending[1]=1 after fire.
- Then `0x00108133` (add x2,x1,x1) → dec_valid=0 until wb_we=1,wb_ad=1; dec_valid=1 the following cycle, ad1=ad2=1.
- `0x00202423` (sw x2,8(x0)) with dec_ready=0 for 3 cycles → outputs held, imm=8, writes_rd=0, instr_ready=0; fires on 4th.
- `0x123452B7` → imm=0x12345000, rd=5; `0xFE000EE3` → imm=0xFFFFFFFC, uses_rs1/rs2=1.
- Opcode 0x7F → illegal=1, flags 0; flush with held valid → dec_valid=0 next cycle, pending unchanged.
- Fire writing x3 same cycle as wb_ad=3 → pending[3]=1; sb_clr → all clear.
